// File: rtl/stack_guard_pmp.sv
// Stack-bounded PMP for Hippomenes: tracks nested interrupt levels and
// checks loads/stores against the active stack window plus grant regions.
module stack_guard_pmp #(
    parameter int AddrWidth  = 16,
    parameter int NumLevels  = 8,
    parameter int NumRegions = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            mem_valid,
    input  logic                            mem_we,
    input  logic [AddrWidth-1:0]            mem_addr,
    input  logic [AddrWidth-1:0]            sp,
    input  logic                            int_enter,
    input  logic [$clog2(NumLevels)-1:0]    enter_level,
    input  logic                            int_exit,
    input  logic                            cfg_we,
    input  logic [$clog2(NumRegions)-1:0]   cfg_idx,
    input  logic [AddrWidth-1:0]            cfg_base,
    input  logic [AddrWidth-1:0]            cfg_limit,
    input  logic [1:0]                      cfg_perm,
    input  logic                            fault_ack,
    output logic                            fault,
    output logic [AddrWidth-1:0]            fault_addr,
    output logic                            fault_is_store,
    output logic [$clog2(NumLevels)-1:0]    fault_level,
    output logic [7:0]                      fault_count,
    output logic [$clog2(NumLevels)-1:0]    cur_level,
    output logic [$clog2(NumLevels):0]      nest_depth
);

    localparam int LW = $clog2(NumLevels);
    localparam int DW = LW + 1;

    typedef enum logic {
        MONITOR,
        FAULTED
    } state_e;

    state_e                 state_q, state_d;
    logic [LW-1:0]          lvl_stack_q [NumLevels];
    logic [AddrWidth-1:0]   entry_sp_q  [NumLevels];
    logic [AddrWidth-1:0]   base_q      [NumRegions];
    logic [AddrWidth-1:0]   limit_q     [NumRegions];
    logic [1:0]             perm_q      [NumRegions];

    logic [LW-1:0]          cur_level_q, cur_level_d;
    logic [DW-1:0]          nest_depth_q, nest_depth_d;
    logic [AddrWidth-1:0]   fault_addr_q;
    logic                   fault_is_store_q;
    logic [LW-1:0]          fault_level_q;
    logic [7:0]             fault_count_q, fault_count_d;

    logic                   full, empty;
    logic                   do_push, do_pop, do_chain, overflow;
    logic [LW-1:0]          push_idx, pop_idx;
    logic                   in_window, region_hit;
    logic                   acc_viol, viol, capture;
    logic [AddrWidth-1:0]   cap_addr;
    logic                   cap_store;

    assign full     = (nest_depth_q == DW'(NumLevels));
    assign empty    = (nest_depth_q == '0);
    assign do_chain = int_enter & int_exit;
    assign overflow = int_enter & ~int_exit & full;
    assign do_push  = int_enter & ~int_exit & ~full;
    assign do_pop   = int_exit & ~int_enter & ~empty;
    assign push_idx = LW'(nest_depth_q);
    assign pop_idx  = LW'(nest_depth_q - DW'(1));

    // Checks see pre-update level state; region writes land next cycle.
    always_comb begin
        region_hit = 1'b0;
        for (int i = 0; i < NumRegions; i++) begin
            if ((base_q[i] <= mem_addr) && (mem_addr <= limit_q[i]) &&
                (mem_we ? perm_q[i][1] : perm_q[i][0])) begin
                region_hit = 1'b1;
            end
        end
    end

    assign in_window = (mem_addr >= sp) &&
                       (mem_addr <= entry_sp_q[cur_level_q]);
    assign acc_viol  = enable & mem_valid & ~empty & ~(in_window | region_hit);
    assign viol      = acc_viol | (enable & overflow);
    assign cap_addr  = acc_viol ? mem_addr : sp;
    assign cap_store = acc_viol ? mem_we : 1'b1;

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            MONITOR: begin
                if (viol) begin
                    state_d = FAULTED;
                    capture = 1'b1;
                end
            end
            FAULTED: begin
                if (fault_ack) begin
                    if (viol) begin
                        capture = 1'b1;
                    end else begin
                        state_d = MONITOR;
                    end
                end
            end
            default: state_d = MONITOR;
        endcase
    end

    always_comb begin
        cur_level_d   = cur_level_q;
        nest_depth_d  = nest_depth_q;
        fault_count_d = fault_count_q;
        if (do_push || do_chain) begin
            cur_level_d = enter_level;
        end else if (do_pop) begin
            cur_level_d = lvl_stack_q[pop_idx];
        end
        if (do_push) begin
            nest_depth_d = nest_depth_q + DW'(1);
        end else if (do_pop) begin
            nest_depth_d = nest_depth_q - DW'(1);
        end
        if (viol && (fault_count_q != 8'hFF)) begin
            fault_count_d = fault_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= MONITOR;
            cur_level_q      <= '0;
            nest_depth_q     <= '0;
            fault_addr_q     <= '0;
            fault_is_store_q <= 1'b0;
            fault_level_q    <= '0;
            fault_count_q    <= '0;
            for (int i = 0; i < NumLevels; i++) begin
                lvl_stack_q[i] <= '0;
                entry_sp_q[i]  <= '0;
            end
            for (int i = 0; i < NumRegions; i++) begin
                base_q[i]  <= '0;
                limit_q[i] <= '0;
                perm_q[i]  <= '0;
            end
        end else begin
            state_q       <= state_d;
            cur_level_q   <= cur_level_d;
            nest_depth_q  <= nest_depth_d;
            fault_count_q <= fault_count_d;
            if (capture) begin
                fault_addr_q     <= cap_addr;
                fault_is_store_q <= cap_store;
                fault_level_q    <= cur_level_q;
            end
            if (do_push) begin
                lvl_stack_q[push_idx] <= cur_level_q;
            end
            if (do_push || do_chain) begin
                entry_sp_q[enter_level] <= sp;
            end
            if (cfg_we) begin
                base_q[cfg_idx]  <= cfg_base;
                limit_q[cfg_idx] <= cfg_limit;
                perm_q[cfg_idx]  <= cfg_perm;
            end
        end
    end

    assign fault          = (state_q == FAULTED);
    assign fault_addr     = fault_addr_q;
    assign fault_is_store = fault_is_store_q;
    assign fault_level    = fault_level_q;
    assign fault_count    = fault_count_q;
    assign cur_level      = cur_level_q;
    assign nest_depth     = nest_depth_q;

endmodule

// File: tb/tb_stack_guard_pmp.sv
// Directed bench for stack_guard_pmp: the driver queues the expected
// post-edge state, a negedge monitor pops and compares it.
module tb_stack_guard_pmp;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_we = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [15:0] sp = '0;
    logic        int_enter = 1'b0;
    logic [2:0]  enter_level = '0;
    logic        int_exit = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = '0;
    logic [15:0] cfg_base = '0;
    logic [15:0] cfg_limit = '0;
    logic [1:0]  cfg_perm = '0;
    logic        fault_ack = 1'b0;
    logic        fault;
    logic [15:0] fault_addr;
    logic        fault_is_store;
    logic [2:0]  fault_level;
    logic [7:0]  fault_count;
    logic [2:0]  cur_level;
    logic [3:0]  nest_depth;

    stack_guard_pmp dut (
        .clk(clk), .reset(reset), .enable(enable),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .sp(sp), .int_enter(int_enter), .enter_level(enter_level),
        .int_exit(int_exit), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_base(cfg_base), .cfg_limit(cfg_limit), .cfg_perm(cfg_perm),
        .fault_ack(fault_ack), .fault(fault), .fault_addr(fault_addr),
        .fault_is_store(fault_is_store), .fault_level(fault_level),
        .fault_count(fault_count), .cur_level(cur_level),
        .nest_depth(nest_depth)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [63:0] nm;
        logic        f;
        logic        ci;
        logic [15:0] a;
        logic        s;
        logic [2:0]  l;
        logic [7:0]  c;
        logic [2:0]  cl;
        logic [3:0]  nd;
    } exp_t;

    exp_t sbq[$];
    exp_t me;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input logic [63:0] nm, input string fld,
                       input logic [15:0] act, input logic [15:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %0s %0s got=%h want=%h", nm, fld, act, ex);
        end
    endtask

    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            me = sbq.pop_front();
            if (me.cyc < cyc) begin
                cmp(me.nm, "stale", 16'(cyc), 16'(me.cyc));
            end else begin
                cmp(me.nm, "fault", 16'(fault), 16'(me.f));
                cmp(me.nm, "count", 16'(fault_count), 16'(me.c));
                cmp(me.nm, "cur_level", 16'(cur_level), 16'(me.cl));
                cmp(me.nm, "depth", 16'(nest_depth), 16'(me.nd));
                if (me.ci) begin
                    cmp(me.nm, "faddr", fault_addr, me.a);
                    cmp(me.nm, "fstore", 16'(fault_is_store), 16'(me.s));
                    cmp(me.nm, "flevel", 16'(fault_level), 16'(me.l));
                end
            end
        end
    end

    // Queue the expected state after the coming edge, then take it.
    task automatic step(input logic [63:0] nm, input logic f, input logic ci,
                        input logic [15:0] a, input logic s, input logic [2:0] l,
                        input logic [7:0] c, input logic [2:0] cl,
                        input logic [3:0] nd);
        exp_t e;
        e.cyc = cyc + 1;
        e.nm = nm; e.f = f; e.ci = ci; e.a = a; e.s = s;
        e.l = l; e.c = c; e.cl = cl; e.nd = nd;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        int_enter = 1'b0;
        int_exit  = 1'b0;
        cfg_we    = 1'b0;
        fault_ack = 1'b0;
    endtask

    task automatic acc(input logic we, input logic [15:0] a);
        mem_valid = 1'b1;
        mem_we    = we;
        mem_addr  = a;
    endtask

    task automatic enter(input logic [2:0] lv, input logic [15:0] s);
        int_enter   = 1'b1;
        enter_level = lv;
        sp          = s;
    endtask

    task automatic cfg(input logic [1:0] i, input logic [15:0] b,
                       input logic [15:0] lim, input logic [1:0] p);
        cfg_we    = 1'b1;
        cfg_idx   = i;
        cfg_base  = b;
        cfg_limit = lim;
        cfg_perm  = p;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        step("rst", 0, 1, 16'h0000, 0, 0, 0, 0, 0);
        reset  = 1'b0;
        enable = 1'b1;

        for (int i = 0; i < 3; i++) begin
            acc(0, 16'h1234);
            step("lvl0", 0, 0, 0, 0, 0, 0, 0, 0);
        end

        enter(3, 16'h0F00);
        step("enter3", 0, 0, 0, 0, 0, 0, 3, 1);
        sp = 16'h0EF0;
        acc(1, 16'h0EF8);
        step("inwin", 0, 0, 0, 0, 0, 0, 3, 1);
        acc(1, 16'h0F04);
        step("above", 1, 1, 16'h0F04, 1, 3, 1, 3, 1);
        fault_ack = 1'b1;
        step("ack1", 0, 0, 0, 0, 0, 1, 3, 1);

        cfg(1, 16'h2000, 16'h20FF, 2'b01);
        enter(2, 16'h1000);
        step("cfg_en2", 0, 0, 0, 0, 0, 1, 2, 2);
        sp = 16'h0FF0;
        acc(0, 16'h2010);
        step("rgn_ld", 0, 0, 0, 0, 0, 1, 2, 2);
        acc(1, 16'h2010);
        step("rgn_st", 1, 1, 16'h2010, 1, 2, 2, 2, 2);
        fault_ack = 1'b1;
        step("ack2", 0, 0, 0, 0, 0, 2, 2, 2);
        cfg(1, 16'h3000, 16'h2000, 2'b11);
        step("cfg_inv", 0, 0, 0, 0, 0, 2, 2, 2);
        acc(0, 16'h2800);
        step("inv_rgn", 1, 1, 16'h2800, 0, 2, 3, 2, 2);
        fault_ack = 1'b1;
        step("ack3", 0, 0, 0, 0, 0, 3, 2, 2);

        int_exit = 1'b1;
        step("ex_a", 0, 0, 0, 0, 0, 3, 3, 1);
        int_exit = 1'b1;
        step("ex_b", 0, 0, 0, 0, 0, 3, 0, 0);

        enter(1, 16'h0800);
        step("n1", 0, 0, 0, 0, 0, 3, 1, 1);
        enter(4, 16'h0700);
        step("n4", 0, 0, 0, 0, 0, 3, 4, 2);
        enter(6, 16'h0600);
        step("n6", 0, 0, 0, 0, 0, 3, 6, 3);
        int_exit = 1'b1;
        step("x4", 0, 0, 0, 0, 0, 3, 4, 2);
        int_exit = 1'b1;
        step("x1", 0, 0, 0, 0, 0, 3, 1, 1);
        int_exit = 1'b1;
        step("x0", 0, 0, 0, 0, 0, 3, 0, 0);
        int_exit = 1'b1;
        step("x_empty", 0, 0, 0, 0, 0, 3, 0, 0);

        for (int i = 0; i < 8; i++) begin
            enter(3'(i), 16'(16'h0100 * (i + 1)));
            step("fill", 0, 0, 0, 0, 0, 3, 3'(i), 4'(i + 1));
        end
        enter(2, 16'h0ABC);
        step("ovf", 1, 1, 16'h0ABC, 1, 7, 4, 7, 8);
        enter(5, 16'h0500);
        int_exit  = 1'b1;
        fault_ack = 1'b1;
        step("chain", 0, 0, 0, 0, 0, 4, 5, 8);

        reset = 1'b1;
        enter(3, 16'h0400);
        cfg(0, 16'h0000, 16'hFFFF, 2'b11);
        acc(1, 16'h6000);
        step("rstmid", 0, 1, 16'h0000, 0, 0, 0, 0, 0);
        reset = 1'b0;

        enter(5, 16'h0500);
        step("en5", 0, 0, 0, 0, 0, 0, 5, 1);
        sp = 16'h04F0;
        acc(1, 16'h6000);
        step("bb1", 1, 1, 16'h6000, 1, 5, 1, 5, 1);
        acc(0, 16'h6004);
        step("bb2", 1, 1, 16'h6000, 1, 5, 2, 5, 1);
        fault_ack = 1'b1;
        acc(1, 16'h6008);
        step("ackv", 1, 1, 16'h6008, 1, 5, 3, 5, 1);

        for (int k = 4; k <= 260; k++) begin
            acc(1, 16'h6010);
            step("sat", 1, 1, 16'h6008, 1, 5, 8'((k > 255) ? 255 : k), 5, 1);
        end
        fault_ack = 1'b1;
        step("ack4", 0, 0, 0, 0, 0, 255, 5, 1);
        enable = 1'b0;
        acc(1, 16'h6010);
        step("dis", 0, 0, 0, 0, 0, 255, 5, 1);

        repeat (3) @(posedge clk);
        #1;
        cmp("drain", "pending", 16'(sbq.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
